eth_fcs_tx_ctrl: RTL and testbench

ETH_FCS_TX_CTRL -- requirements
Module: eth_fcs_tx_ctrl

---
 rtl/eth_fcs_tx_ctrl.sv | 177 +++++++++++++++++
 tb/tb_eth_fcs_tx_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fcs_tx_ctrl.sv
// Ethernet TX framer: forwards payload, optionally pads to MIN_LEN, appends a 4-byte FCS from an external CRC engine, then enforces an inter-frame gap.
// Optional feature macro: ETH_FCS_PAD_EN (compiles in the PAD state for short frames).
module eth_fcs_tx_ctrl #(
  parameter int MIN_LEN    = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [7:0]  crc_data,
  output logic        crc_en,
  output logic        crc_clr,
  input  logic [31:0] crc_result,
  output logic        frame_done
);

  if (MIN_LEN < 1 || MIN_LEN > 63) begin : g_bad_min_len
    $error("eth_fcs_tx_ctrl: MIN_LEN must be within 1..63");
  end
  if (IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_bad_ifg
    $error("eth_fcs_tx_ctrl: IFG_CYCLES must be within 1..255");
  end

`ifdef ETH_FCS_PAD_EN
  localparam logic [5:0] MIN_LEN_C = 6'(MIN_LEN);
`endif
  localparam logic [7:0] GAP_INIT = 8'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
`ifdef ETH_FCS_PAD_EN
    PAD,
`endif
    FCS,
    GAP
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  count, count_nxt, count_inc;
  logic [31:0] fcs_latch, fcs_latch_nxt;
  logic [1:0]  fcs_idx, fcs_idx_nxt;
  logic [7:0]  gap_cnt, gap_cnt_nxt;
  logic [7:0]  m_data_nxt;
  logic        m_valid_nxt, m_last_nxt;
  logic        load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      fcs_latch <= '0;
      fcs_idx   <= '0;
      gap_cnt   <= '0;
      m_data    <= 8'h00;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      fcs_latch <= fcs_latch_nxt;
      fcs_idx   <= fcs_idx_nxt;
      gap_cnt   <= gap_cnt_nxt;
      m_data    <= m_data_nxt;
      m_valid   <= m_valid_nxt;
      m_last    <= m_last_nxt;
    end
  end

  always_comb begin
    load          = !m_valid || m_ready;
    count_inc     = (count == 6'd63) ? count : count + 6'd1;
    state_nxt     = state;
    count_nxt     = count;
    fcs_latch_nxt = fcs_latch;
    fcs_idx_nxt   = fcs_idx;
    gap_cnt_nxt   = gap_cnt;
    m_data_nxt    = m_data;
    m_valid_nxt   = m_valid;
    m_last_nxt    = m_last;
    s_ready       = 1'b0;
    crc_en        = 1'b0;
    crc_data      = s_data;
    crc_clr       = 1'b0;

    // Held byte drained with nothing new behind it; any load below overrides this.
    if (m_valid && m_ready) begin
      m_valid_nxt = 1'b0;
      m_last_nxt  = 1'b0;
    end

    case (state)
      IDLE, PAYLOAD: begin
        crc_clr = (state == IDLE);
        s_ready = load;
        if (s_valid && load) begin
          crc_en      = 1'b1;
          m_data_nxt  = s_data;
          m_valid_nxt = 1'b1;
          m_last_nxt  = 1'b0;
          count_nxt   = count_inc;
          fcs_idx_nxt = 2'd0;
          if (s_last) begin
`ifdef ETH_FCS_PAD_EN
            state_nxt = (count_inc < MIN_LEN_C) ? PAD : FCS;
`else
            state_nxt = FCS;
`endif
          end else begin
            state_nxt = PAYLOAD;
          end
        end
      end
`ifdef ETH_FCS_PAD_EN
      PAD: begin
        crc_data = 8'h00;
        if (load) begin
          crc_en      = 1'b1;
          m_data_nxt  = 8'h00;
          m_valid_nxt = 1'b1;
          m_last_nxt  = 1'b0;
          count_nxt   = count_inc;
          if (count_inc == MIN_LEN_C) state_nxt = FCS;
        end
      end
`endif
      FCS: begin
        // Once the final byte is loaded, wait for its handshake before the gap.
        if (m_valid && m_last) begin
          if (m_ready) begin
            state_nxt   = GAP;
            count_nxt   = '0;
            gap_cnt_nxt = GAP_INIT;
          end
        end else if (load) begin
          m_valid_nxt = 1'b1;
          m_last_nxt  = 1'b0;
          fcs_idx_nxt = fcs_idx + 2'd1;
          case (fcs_idx)
            2'd0: begin
              m_data_nxt    = crc_result[31:24];
              fcs_latch_nxt = crc_result;
            end
            2'd1: m_data_nxt = fcs_latch[23:16];
            2'd2: m_data_nxt = fcs_latch[15:8];
            default: begin
              m_data_nxt = fcs_latch[7:0];
              m_last_nxt = 1'b1;
            end
          endcase
        end
      end
      GAP: begin
        crc_clr = 1'b1;
        if (gap_cnt == 8'd0) state_nxt = IDLE;
        else gap_cnt_nxt = gap_cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      s_ready = 1'b0;
      crc_en  = 1'b0;
      crc_clr = 1'b1;
    end
  end

  assign frame_done = !rst && m_valid && m_ready && m_last;

endmodule

// File: tb/tb_eth_fcs_tx_ctrl.sv
// Directed bench for eth_fcs_tx_ctrl; expectations follow ETH_FCS_PAD_EN when defined.
module tb_eth_fcs_tx_ctrl;
  localparam int MIN_LEN    = 60;
  localparam int IFG_CYCLES = 12;
`ifdef ETH_FCS_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b1;
  logic [31:0] crc_result = 32'h11223344;
  logic        s_ready, m_valid, m_last, crc_en, crc_clr, frame_done;
  logic [7:0]  m_data, crc_data;

  eth_fcs_tx_ctrl #(.MIN_LEN(MIN_LEN), .IFG_CYCLES(IFG_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .crc_data(crc_data), .crc_en(crc_en), .crc_clr(crc_clr),
    .crc_result(crc_result), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ready_mode = 1;  // 0 = low, 1 = high, 2 = random

  logic [7:0] out_q[$];
  logic       last_q[$];
  logic [7:0] exp_q[$];
  int crc_en_cnt = 0, crc_zero_cnt = 0, stall_en_cnt = 0, done_cnt = 0;
  int mark_out, mark_en, mark_zero, mark_stall, mark_done;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: m_ready = 1'b0;
      1: m_ready = 1'b1;
      default: m_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        out_q.push_back(m_data);
        last_q.push_back(m_last);
      end
      if (crc_en) begin
        crc_en_cnt++;
        if (crc_data == 8'h00) crc_zero_cnt++;
        if (m_valid && !m_ready) stall_en_cnt++;
      end
      if (frame_done) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  task automatic mark();
    mark_out   = out_q.size();
    mark_en    = crc_en_cnt;
    mark_zero  = crc_zero_cnt;
    mark_stall = stall_en_cnt;
    mark_done  = done_cnt;
  endtask

  function automatic void build_exp(input int len, input logic [7:0] base, input logic [31:0] crc);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(8'(base + i));
    if (PAD_ON) while (exp_q.size() < MIN_LEN) exp_q.push_back(8'h00);
    exp_q.push_back(crc[31:24]);
    exp_q.push_back(crc[23:16]);
    exp_q.push_back(crc[15:8]);
    exp_q.push_back(crc[7:0]);
  endfunction

  function automatic int frame_diffs();
    int n = 0;
    int got = out_q.size() - mark_out;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got) n++;
      else begin
        if (out_q[mark_out + i] !== exp_q[i]) n++;
        if (last_q[mark_out + i] !== (i == exp_q.size() - 1)) n++;
      end
    end
    return n;
  endfunction

  task automatic send_frame(input int len, input logic [7:0] base, input bit with_last);
    for (int i = 0; i < len; i++) begin
      int guard = 0;
      bit done = 0;
      s_valid = 1'b1;
      s_data  = 8'(base + i);
      s_last  = with_last && (i == len - 1);
      while (!done) begin
        @(negedge clk);
        done = s_ready;
        @(posedge clk); #1;
        guard++;
        if (!done && guard > 2000) begin
          checks++; errors++;
          $display("FAIL send_timeout: byte %0d never accepted, required acceptance", i);
          done = 1;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_frame_done(input string name);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (frame_done) break;
      n++;
      if (n > 5000) begin
        checks++; errors++;
        $display("FAIL %s_done_timeout: no frame_done, required one", name);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %b want 0", m_last); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rst_m_data: got %h want 00", m_data); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    checks++; if (crc_clr !== 1'b1) begin errors++; $display("FAIL rst_crc_clr: got %b want 1", crc_clr); end
    checks++; if (crc_en !== 1'b0) begin errors++; $display("FAIL rst_crc_en: got %b want 0", crc_en); end
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL idle_s_ready: got %b want 1", s_ready); end
    checks++; if (crc_clr !== 1'b1) begin errors++; $display("FAIL idle_crc_clr: got %b want 1", crc_clr); end
    @(posedge clk); #1;
  endtask

  task automatic test_long_frame();
    int d;
    ready_mode = 1; crc_result = 32'h11223344;
    mark();
    send_frame(64, 8'h00, 1'b1);
    @(posedge clk); #2;
    crc_result = 32'hDEADBEEF;  // bytes 1-3 must come from the latched value
    wait_frame_done("long");
    @(posedge clk); #1;
    crc_result = 32'h11223344;
    build_exp(64, 8'h00, 32'h11223344);
    d = frame_diffs();
    checks++; if (out_q.size() - mark_out !== 68) begin errors++; $display("FAIL long_len: got %0d want 68", out_q.size() - mark_out); end
    checks++; if (d !== 0) begin errors++; $display("FAIL long_bytes: got %0d bad positions want 0", d); end
    checks++; if (crc_en_cnt - mark_en !== 64) begin errors++; $display("FAIL long_crc_en: got %0d want 64", crc_en_cnt - mark_en); end
    checks++; if (done_cnt - mark_done !== 1) begin errors++; $display("FAIL long_done: got %0d want 1", done_cnt - mark_done); end
    wait_idle();
  endtask

  task automatic test_pad();
    int d;
    mark();
    send_frame(10, 8'hA0, 1'b1);
    wait_frame_done("pad");
    @(posedge clk); #1;
    build_exp(10, 8'hA0, crc_result);
    d = frame_diffs();
    checks++; if (out_q.size() - mark_out !== (PAD_ON ? 64 : 14)) begin errors++; $display("FAIL pad_len: got %0d want %0d", out_q.size() - mark_out, PAD_ON ? 64 : 14); end
    checks++; if (d !== 0) begin errors++; $display("FAIL pad_bytes: got %0d bad positions want 0", d); end
    checks++; if (crc_en_cnt - mark_en !== (PAD_ON ? 60 : 10)) begin errors++; $display("FAIL pad_crc_en: got %0d want %0d", crc_en_cnt - mark_en, PAD_ON ? 60 : 10); end
    checks++; if (crc_zero_cnt - mark_zero !== (PAD_ON ? 50 : 0)) begin errors++; $display("FAIL pad_zero_en: got %0d want %0d", crc_zero_cnt - mark_zero, PAD_ON ? 50 : 0); end
    wait_idle();
  endtask

  task automatic test_one_byte();
    int d;
    mark();
    send_frame(1, 8'h5A, 1'b1);
    wait_frame_done("one");
    @(posedge clk); #1;
    build_exp(1, 8'h5A, crc_result);
    d = frame_diffs();
    checks++; if (out_q.size() - mark_out !== (PAD_ON ? 64 : 5)) begin errors++; $display("FAIL one_len: got %0d want %0d", out_q.size() - mark_out, PAD_ON ? 64 : 5); end
    checks++; if (d !== 0) begin errors++; $display("FAIL one_bytes: got %0d bad positions want 0", d); end
    checks++; if (crc_en_cnt - mark_en !== (PAD_ON ? 60 : 1)) begin errors++; $display("FAIL one_crc_en: got %0d want %0d", crc_en_cnt - mark_en, PAD_ON ? 60 : 1); end
    checks++; if (done_cnt - mark_done !== 1) begin errors++; $display("FAIL one_done: got %0d want 1", done_cnt - mark_done); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int low = 0, bad_clr = 0, bad_act = 0, d;
    send_frame(64, 8'h00, 1'b1);
    wait_frame_done("b2b_first");
    s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;  // offered during the gap, must be ignored
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (s_ready) break;
      low++;
      if (!crc_clr) bad_clr++;
      if (crc_en || m_valid) bad_act++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (low !== IFG_CYCLES) begin errors++; $display("FAIL b2b_gap_len: got %0d want %0d", low, IFG_CYCLES); end
    checks++; if (bad_clr !== 0) begin errors++; $display("FAIL b2b_gap_crc_clr: got %0d low cycles want 0", bad_clr); end
    checks++; if (bad_act !== 0) begin errors++; $display("FAIL b2b_gap_activity: got %0d busy cycles want 0", bad_act); end
    @(posedge clk); #1;
    mark();
    send_frame(64, 8'h80, 1'b1);
    wait_frame_done("b2b_second");
    @(posedge clk); #1;
    build_exp(64, 8'h80, crc_result);
    d = frame_diffs();
    checks++; if (out_q.size() - mark_out !== 68) begin errors++; $display("FAIL b2b_len: got %0d want 68", out_q.size() - mark_out); end
    checks++; if (d !== 0) begin errors++; $display("FAIL b2b_bytes: got %0d bad positions want 0", d); end
    checks++; if (done_cnt - mark_done !== 1) begin errors++; $display("FAIL b2b_done: got %0d want 1", done_cnt - mark_done); end
    wait_idle();
  endtask

  task automatic test_stall();
    int d;
    ready_mode = 2;
    mark();
    send_frame(64, 8'h00, 1'b1);
    wait_frame_done("stall");
    @(posedge clk); #1;
    ready_mode = 1;
    build_exp(64, 8'h00, crc_result);
    d = frame_diffs();
    checks++; if (out_q.size() - mark_out !== 68) begin errors++; $display("FAIL stall_len: got %0d want 68", out_q.size() - mark_out); end
    checks++; if (d !== 0) begin errors++; $display("FAIL stall_bytes: got %0d bad positions want 0", d); end
    checks++; if (crc_en_cnt - mark_en !== 64) begin errors++; $display("FAIL stall_crc_en: got %0d want 64", crc_en_cnt - mark_en); end
    checks++; if (stall_en_cnt - mark_stall !== 0) begin errors++; $display("FAIL stall_frozen_en: got %0d want 0", stall_en_cnt - mark_stall); end
    checks++; if (done_cnt - mark_done !== 1) begin errors++; $display("FAIL stall_done: got %0d want 1", done_cnt - mark_done); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int d;
    mark();
    send_frame(30, 8'h00, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_s_ready: got %b want 1", s_ready); end
    checks++; if (crc_clr !== 1'b1) begin errors++; $display("FAIL midrst_crc_clr: got %b want 1", crc_clr); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (done_cnt - mark_done !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt - mark_done); end
    mark();
    send_frame(64, 8'h40, 1'b1);
    wait_frame_done("midrst");
    @(posedge clk); #1;
    build_exp(64, 8'h40, crc_result);
    d = frame_diffs();
    checks++; if (out_q.size() - mark_out !== 68) begin errors++; $display("FAIL midrst_len: got %0d want 68", out_q.size() - mark_out); end
    checks++; if (d !== 0) begin errors++; $display("FAIL midrst_bytes: got %0d bad positions want 0", d); end
    checks++; if (done_cnt - mark_done !== 1) begin errors++; $display("FAIL midrst_done: got %0d want 1", done_cnt - mark_done); end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_long_frame();
    test_pad();
    test_one_byte();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
